seq_chk: RTL and testbench
==========================

SEQ_CHK -- requirements
Module: seq_chk

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data width in bits.
REQ-002 The block SHALL have parameter ACQ_CNT, default 4, meaning consecutive matches needed to declare sync (legal range 1..15).
REQ-003 The block SHALL have parameter LOSS_CNT, default 3, meaning consecutive mismatches in SYNC needed to declare loss (legal range 1..15).
REQ-004 The block SHALL have port clkin, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port rstin, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port locked, input, 1 bit, high when the upstream capture clock (DCM) is locked.
REQ-007 The block SHALL have port datain, input, DW bits, the captured data word from the upstream capture stage.
REQ-008 The block SHALL have port valid, input, 1 bit, qualifier: datain is sampled only when valid=1.
REQ-009 The block SHALL have port match, output, 1 bit, registered result of the last compare.
REQ-010 The block SHALL have port err_pulse, output, 1 bit, one-cycle pulse per mismatch while in SYNC.
REQ-011 The block SHALL have port in_sync, output, 1 bit, high while the FSM is in SYNC.
REQ-012 The block SHALL have port err_count, output, 16 bits, count of SYNC mismatches.

Function
REQ-013 A sample SHALL occur on a rising clkin edge when valid=1 and locked=1; no other edge changes prev, streaks or counters.
REQ-014 The expected value SHALL be prev+1 modulo 2^DW; the wrap from all-ones to zero SHALL count as a match.
REQ-015 Every sample SHALL load prev with datain, whether it matches or not.
REQ-016 match SHALL update one cycle after the sample edge and hold its value between samples; it is forced to 0 in IDLE.
REQ-017 The FSM SHALL have four states: IDLE, PRIME, ACQUIRE and SYNC.
REQ-018 IDLE SHALL go to PRIME on the first cycle with locked=1.
REQ-019 In PRIME, the first sample SHALL load prev without a compare and move the FSM to ACQUIRE with the good streak at 0.
REQ-020 In ACQUIRE, a match SHALL increment the good streak, and a mismatch SHALL clear it; when the streak reaches ACQ_CNT the FSM SHALL go to SYNC and clear the bad streak.
REQ-021 In SYNC, a mismatch SHALL assert err_pulse for exactly one cycle (aligned with match=0) and increment the bad streak; a match SHALL clear the bad streak.
REQ-022 When the bad streak reaches LOSS_CNT, the FSM SHALL go to ACQUIRE with both streaks cleared; in_sync SHALL drop in the same cycle that err_pulse asserts for that mismatch.
REQ-023 A locked=0 in any state SHALL send the FSM to IDLE on the next edge, taking priority over a simultaneous sample; streaks SHALL clear, while err_count and prev SHALL hold.
REQ-024 err_pulse SHALL never assert outside SYNC.
REQ-025 A single corrupted word in an incrementing stream SHALL produce two consecutive mismatches, because of REQ-015.

Reset
REQ-026 On rstin=0, the block SHALL go immediately to IDLE with prev=0, both streaks=0, match=0, err_pulse=0, in_sync=0 and err_count=0.
REQ-027 Reset release SHALL be treated as a normal input; an operation interrupted by reset SHALL restart from IDLE with no residual state.

Configuration
REQ-028 With macro SEQ_CHK_STATS_EN defined, err_count SHALL increment on each err_pulse and saturate at 16'hFFFF.
REQ-029 Without SEQ_CHK_STATS_EN, err_count SHALL be tied to 0 and no counter logic SHALL be present; all other behaviour SHALL be unchanged.

Verification
REQ-030 Bench SHALL check: locked=1, valid=1, datain 0x00,0x01,0x02,... -> in_sync=1 after 5 samples (1 prime + 4 matches), with err_pulse never asserted.
REQ-031 Bench SHALL check: in SYNC, the sequence ...0xFE,0xFF,0x00,0x01 -> match stays 1 across the wrap, with no err_pulse.
REQ-032 Bench SHALL check: in SYNC, a stream of 0x10,0x11,0x55,0x13 -> two err_pulses, in_sync stays 1, and err_count=2 with SEQ_CHK_STATS_EN defined.
REQ-033 Bench SHALL check: in SYNC, three consecutive bad words -> in_sync=0 on the third err_pulse, FSM in ACQUIRE, and re-sync after 4 further matches.
REQ-034 Bench SHALL check: locked deasserted mid-stream together with valid=1 -> FSM in IDLE next cycle, match=0, in_sync=0, and err_count held.
REQ-035 Bench SHALL check: rstin=0 asserted between clock edges while in SYNC -> all outputs 0 immediately; after release, locked=1 and an incrementing stream -> in_sync=1 after 5 samples.

Source files
------------

// File: rtl/seq_chk.sv
// Incrementing-sequence checker: PRIME/ACQUIRE/SYNC lock FSM. Outputs are registered one cycle after the sample edge.
// No backpressure: a word is sampled on any edge with valid & locked. SEQ_CHK_STATS_EN enables the saturating err_count.
module seq_chk #(
  parameter int DW       = 8,
  parameter int ACQ_CNT  = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic          clkin,
  input  logic          rstin,
  input  logic          locked,
  input  logic [DW-1:0] datain,
  input  logic          valid,
  output logic          match,
  output logic          err_pulse,
  output logic          in_sync,
  output logic [15:0]   err_count
);

  typedef enum logic [1:0] {IDLE, PRIME, ACQUIRE, SYNC} state_t;

  localparam logic [3:0] ACQ_LAST  = 4'(ACQ_CNT - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);

  state_t        state, state_nxt;
  logic [DW-1:0] prev, prev_nxt;
  logic [DW-1:0] nxt_exp;
  logic [3:0]    good, good_nxt;
  logic [3:0]    bad, bad_nxt;
  logic          match_nxt;
  logic          err_nxt;
  logic          hit;

  // Natural DW-bit wrap makes all-ones -> zero a match.
  assign nxt_exp = prev + {{(DW-1){1'b0}}, 1'b1};
  assign hit     = (datain == nxt_exp);
  assign in_sync = (state == SYNC);

  always_ff @(posedge clkin or negedge rstin) begin
    if (!rstin) begin
      state     <= IDLE;
      prev      <= '0;
      good      <= '0;
      bad       <= '0;
      match     <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      good      <= good_nxt;
      bad       <= bad_nxt;
      match     <= match_nxt;
      err_pulse <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    good_nxt  = good;
    bad_nxt   = bad;
    match_nxt = match;
    err_nxt   = 1'b0;
    // Loss of lock wins over any word presented on the same edge.
    if (!locked) begin
      state_nxt = IDLE;
      good_nxt  = '0;
      bad_nxt   = '0;
      match_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = PRIME;
          match_nxt = 1'b0;
        end
        PRIME: begin
          if (valid) begin
            prev_nxt  = datain;
            good_nxt  = '0;
            match_nxt = 1'b0;
            state_nxt = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (valid) begin
            prev_nxt  = datain;
            match_nxt = hit;
            if (!hit) begin
              good_nxt = '0;
            end else if (good == ACQ_LAST) begin
              good_nxt  = '0;
              bad_nxt   = '0;
              state_nxt = SYNC;
            end else begin
              good_nxt = good + 4'd1;
            end
          end
        end
        SYNC: begin
          if (valid) begin
            prev_nxt  = datain;
            match_nxt = hit;
            if (hit) begin
              bad_nxt = '0;
            end else begin
              err_nxt = 1'b1;
              if (bad == LOSS_LAST) begin
                good_nxt  = '0;
                bad_nxt   = '0;
                state_nxt = ACQUIRE;
              end else begin
                bad_nxt = bad + 4'd1;
              end
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef SEQ_CHK_STATS_EN
  logic [15:0] cnt;

  always_ff @(posedge clkin or negedge rstin) begin
    if (!rstin) begin
      cnt <= '0;
    end else if (err_nxt && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign err_count = cnt;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_seq_chk.sv
// Self-checking bench for seq_chk: directed scenarios plus a randomized stream against an event-level model.
module tb_seq_chk;

  logic       clkin;
  logic       rstin;
  logic       locked;
  logic [7:0] datain;
  logic       valid;
  logic       match;
  logic       err_pulse;
  logic       in_sync;
  logic [15:0] err_count;

  int checks;
  int failures;

  seq_chk #(.DW(8), .ACQ_CNT(4), .LOSS_CNT(3)) dut (
    .clkin     (clkin),
    .rstin     (rstin),
    .locked    (locked),
    .datain    (datain),
    .valid     (valid),
    .match     (match),
    .err_pulse (err_pulse),
    .in_sync   (in_sync),
    .err_count (err_count)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Reference model, advanced once per clock edge from the driven inputs.
  // mode: 0 = waiting for lock, 1 = first word pending, 2 = hunting, 3 = locked on.
  int       m_mode;
  bit [7:0] m_prev;
  int       m_good;
  int       m_bad;
  bit       m_match;
  bit       m_err;
  int       m_cnt;
  bit       m_match_dc;
  int       err_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_prev = 8'h00; m_good = 0; m_bad = 0;
    m_match = 1'b0; m_err = 1'b0; m_cnt = 0; m_match_dc = 1'b0;
  endtask

  task automatic model_edge(input bit lk, input bit vl, input bit [7:0] d);
    bit [7:0] want;
    bit       ok;
    want  = m_prev + 8'd1;
    ok    = (d == want);
    m_err = 1'b0;
    if (!lk) begin
      m_mode = 0; m_good = 0; m_bad = 0; m_match = 1'b0; m_match_dc = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_match = 1'b0;
    end else if (vl) begin
      if (m_mode == 1) begin
        m_mode = 2; m_good = 0; m_match = 1'b0; m_match_dc = 1'b1;
      end else begin
        m_match = ok; m_match_dc = 1'b0;
        if (m_mode == 2) begin
          m_good = ok ? m_good + 1 : 0;
          if (m_good == 4) begin m_mode = 3; m_good = 0; m_bad = 0; end
        end else begin
          if (ok) m_bad = 0;
          else begin
            m_err = 1'b1;
            m_bad = m_bad + 1;
            if (m_bad == 3) begin m_mode = 2; m_good = 0; m_bad = 0; end
          end
        end
      end
      m_prev = d;
    end
`ifdef SEQ_CHK_STATS_EN
    if (m_err && m_cnt < 65535) m_cnt++;
`endif
  endtask

  // Called at posedge+1; drives inputs, crosses one edge, then compares with the model.
  task automatic step(input bit lk, input bit vl, input bit [7:0] d);
    locked = lk; valid = vl; datain = d;
    @(posedge clkin); #1;
    model_edge(lk, vl, d);
    if (err_pulse) err_seen++;
    chk("in_sync", 32'(in_sync), 32'(m_mode == 3));
    chk("err_pulse", 32'(err_pulse), 32'(m_err));
    if (!m_match_dc) chk("match", 32'(match), 32'(m_match));
    chk("err_count", 32'(err_count), 32'(m_cnt));
  endtask

  task automatic do_reset();
    locked = 1'b0; valid = 1'b0; datain = 8'h00;
    rstin = 1'b0;
    #1;
    chk("rst_in_sync", 32'(in_sync), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clkin); #1;
    rstin = 1'b1;
    model_reset();
  endtask

  // One lock-wait edge, then an incrementing stream from 'start'; checks sync after exactly 5 samples.
  task automatic acquire_from(input bit [7:0] start, input string tag);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, start + 8'(i));
      if (i == 3) chk({tag, "_not_yet"}, 32'(in_sync), 32'd0);
    end
    chk({tag, "_sync"}, 32'(in_sync), 32'd1);
  endtask

  function automatic int exp_cnt(input int n);
`ifdef SEQ_CHK_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  bit [7:0] last;
  bit [7:0] d;
  int       base;

  initial begin
    checks = 0; failures = 0; err_seen = 0;
    model_reset();
    #2;
    do_reset();

    // Acquire on a stream starting at 0x00.
    acquire_from(8'h00, "acq");
    chk("acq_no_err", 32'(err_seen), 32'd0);

    // Run up to 0xFE, then cross the wrap.
    for (int v = 5; v <= 8'hFE; v++) step(1'b1, 1'b1, 8'(v));
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'h00);
    chk("wrap_match", 32'(match), 32'd1);
    chk("wrap_no_err", 32'(err_pulse), 32'd0);
    step(1'b1, 1'b1, 8'h01);
    chk("wrap_match2", 32'(match), 32'd1);
    chk("wrap_no_err_total", 32'(err_seen), 32'd0);

    // Single corrupted word yields two error pulses but keeps sync.
    for (int v = 2; v <= 8'h11; v++) step(1'b1, 1'b1, 8'(v));
    step(1'b1, 1'b1, 8'h55);
    chk("corrupt_err1", 32'(err_pulse), 32'd1);
    step(1'b1, 1'b1, 8'h13);
    chk("corrupt_err2", 32'(err_pulse), 32'd1);
    chk("corrupt_sync", 32'(in_sync), 32'd1);
    step(1'b1, 1'b1, 8'h14);
    chk("corrupt_pulses", 32'(err_seen), 32'd2);
    chk("corrupt_count", 32'(err_count), 32'(exp_cnt(2)));

    // Three bad words drop sync on the third pulse, then four matches re-sync.
    step(1'b1, 1'b1, 8'h15);
    step(1'b1, 1'b1, 8'h80);
    step(1'b1, 1'b1, 8'h90);
    chk("loss_still_sync", 32'(in_sync), 32'd1);
    step(1'b1, 1'b1, 8'hA0);
    chk("loss_err", 32'(err_pulse), 32'd1);
    chk("loss_sync", 32'(in_sync), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 8'hA0 + 8'(i));
      if (i == 3) chk("resync_not_yet", 32'(in_sync), 32'd0);
    end
    chk("resync", 32'(in_sync), 32'd1);

    // Lock loss with a valid word present.
    step(1'b0, 1'b1, 8'hA5);
    chk("unlock_sync", 32'(in_sync), 32'd0);
    chk("unlock_match", 32'(match), 32'd0);
    chk("unlock_count", 32'(err_count), 32'(exp_cnt(5)));
    // Back in the lock-wait state: the first locked edge must not sample, so sync needs 1 + 5 edges.
    acquire_from(8'h30, "relock");
    chk("relock_count", 32'(err_count), 32'(exp_cnt(5)));

    // Asynchronous reset between edges while in sync.
    step(1'b1, 1'b1, 8'h35);
    #3;
    rstin = 1'b0;
    #1;
    chk("arst_sync", 32'(in_sync), 32'd0);
    chk("arst_match", 32'(match), 32'd0);
    chk("arst_err_pulse", 32'(err_pulse), 32'd0);
    chk("arst_count", 32'(err_count), 32'd0);
    locked = 1'b0; valid = 1'b0;
    @(posedge clkin); #1;
    rstin = 1'b1;
    model_reset();
    acquire_from(8'h00, "post_rst");

    // Randomized stream: mostly incrementing, with corruption, gaps and lock drops.
    last = 8'h00;
    base = err_seen;
    for (int n = 0; n < 3000; n++) begin
      bit lk, vl;
      lk = ($urandom_range(0, 63) != 0);
      vl = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : last + 8'd1;
      step(lk, vl, d);
      if (lk && vl) last = d;
    end
    chk("rand_pulses_seen", 32'(err_seen > base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
